// File: rtl/button_pkg.sv
// Shared types and elaboration helpers for the button event generator.
package button_pkg;

    typedef enum logic [1:0] {
        ARM     = 2'd0,
        IDLE    = 2'd1,
        PRESSED = 2'd2,
        LONG    = 2'd3
    } state_e;

    function automatic int clk_per_ms(input int system_clock);
        return system_clock / 1000;
    endfunction

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int counter_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every CLK_PER_MS clocks, restartable.
module ms_tick_gen
    import button_pkg::*;
#(
    parameter int CLK_PER_MS = 50000
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic clear_i,
    output logic tick_o
);

    localparam int              CNT_W = counter_width(CLK_PER_MS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_PER_MS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tick_o = (cnt_q == LAST);
        cnt_d  = (clear_i || tick_o) ? '0 : cnt_q + CNT_W'(1);
    end

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/button_event_gen.sv
// Turns a debounced button level into press/release/long/repeat strobes and a held level.
module button_event_gen
    import button_pkg::*;
#(
    parameter int SYSTEM_CLOCK = 50000000,
    parameter int LONG_MS      = 1000,
    parameter int REPEAT_MS    = 200,
    parameter bit REPEAT_EN    = 1'b1
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic btn_i,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o,
    output logic held_o
);

    localparam int               CLK_PER_MS  = clk_per_ms(SYSTEM_CLOCK);
    localparam int               MS_W        = counter_width(max_int(LONG_MS, REPEAT_MS) + 1);
    localparam logic [MS_W-1:0]  LONG_LAST   = MS_W'(LONG_MS - 1);
    localparam logic [MS_W-1:0]  REPEAT_LAST = MS_W'(REPEAT_MS - 1);

    state_e          state_q, state_d;
    logic [MS_W-1:0] ms_q, ms_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            long_q, long_d;
    logic            repeat_q, repeat_d;
    logic            held_q, held_d;
    logic            presc_clear;
    logic            ms_tick;

    ms_tick_gen #(
        .CLK_PER_MS (CLK_PER_MS)
    ) u_ms_tick_gen (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .clear_i  (presc_clear),
        .tick_o   (ms_tick)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        ms_d        = ms_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        repeat_d    = 1'b0;
        held_d      = 1'b0;
        presc_clear = 1'b0;

        case (state_q)
            ARM: begin
                presc_clear = 1'b1;
                ms_d        = '0;
                if (!btn_i) state_d = IDLE;
            end
            IDLE: begin
                // Holding the prescaler at zero here aligns all timing to the press edge.
                presc_clear = 1'b1;
                ms_d        = '0;
                if (btn_i) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                    held_d  = 1'b1;
                end
            end
            PRESSED, LONG: begin
                held_d = 1'b1;
                // Release is checked first so it wins over a coincident terminal tick.
                if (!btn_i) begin
                    state_d     = IDLE;
                    release_d   = 1'b1;
                    ms_d        = '0;
                    presc_clear = 1'b1;
                end else if (ms_tick) begin
                    if (state_q == PRESSED && ms_q == LONG_LAST) begin
                        state_d     = LONG;
                        long_d      = 1'b1;
                        ms_d        = '0;
                        presc_clear = 1'b1;
                    end else if (state_q == LONG && ms_q == REPEAT_LAST) begin
                        repeat_d    = REPEAT_EN;
                        ms_d        = '0;
                        presc_clear = 1'b1;
                    end else begin
                        ms_d = ms_q + MS_W'(1);
                    end
                end
            end
            default: state_d = ARM;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= ARM;
            ms_q      <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ms_q      <= ms_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;
    assign repeat_o  = repeat_q;
    assign held_o    = held_q;

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench: two instances (auto-repeat on/off) share stimulus; CLK_PER_MS=4, LONG_MS=10, REPEAT_MS=5.
module tb_button_event_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic btn;
    logic p0, r0, l0, rp0, h0;
    logic p1, r1, l1, rp1, h1;

    int checks = 0;
    int errors = 0;

    // Output vector order: {press, release, long, repeat, held}
    typedef struct {
        logic       b;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    button_event_gen #(
        .SYSTEM_CLOCK (4000),
        .LONG_MS      (10),
        .REPEAT_MS    (5),
        .REPEAT_EN    (1'b1)
    ) u_dut_rep (
        .clk_i     (clk),
        .reset_ni  (rst_n),
        .btn_i     (btn),
        .press_o   (p0),
        .release_o (r0),
        .long_o    (l0),
        .repeat_o  (rp0),
        .held_o    (h0)
    );

    button_event_gen #(
        .SYSTEM_CLOCK (4000),
        .LONG_MS      (10),
        .REPEAT_MS    (5),
        .REPEAT_EN    (1'b0)
    ) u_dut_norep (
        .clk_i     (clk),
        .reset_ni  (rst_n),
        .btn_i     (btn),
        .press_o   (p1),
        .release_o (r1),
        .long_o    (l1),
        .repeat_o  (rp1),
        .held_o    (h1)
    );

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b {press,release,long,repeat,held} at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_both(input string name, input logic [4:0] exp);
        check({name, " rep_en=1"}, {p0, r0, l0, rp0, h0}, exp);
        check({name, " rep_en=0"}, {p1, r1, l1, rp1, h1}, exp & 5'b11101);
        checks++;
        if (!$onehot0({p0, r0, l0, rp0})) begin
            errors++;
            $display("FAIL %s onehot: strobes %b want at most one set", name, {p0, r0, l0, rp0});
        end
    endtask

    // Drive btn at a falling edge, let one rising edge sample it, compare at the next falling edge.
    task automatic step(input logic b, input logic [4:0] exp, input string name);
        btn = b;
        @(negedge clk);
        check_both(name, exp);
    endtask

    // Holds the button for n cycles from IDLE; t counts cycles after the press_o cycle.
    task automatic press_hold(input int n, input bit do_release, input string name);
        logic [4:0] exp;
        for (int t = 0; t < n; t++) begin
            exp = {t == 0, 1'b0, t == 40, (t > 40) && ((t - 40) % 20 == 0), 1'b1};
            step(1'b1, exp, name);
        end
        if (do_release) begin
            step(1'b0, 5'b01001, {name, " release"});
            step(1'b0, 5'b00000, {name, " idle"});
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'b10001};  // single-cycle pulse: press
        vecs[1] = '{1'b0, 5'b01001};  // release on the following cycle
        vecs[2] = '{1'b0, 5'b00000};
        vecs[3] = '{1'b1, 5'b10001};
        vecs[4] = '{1'b1, 5'b00001};
        vecs[5] = '{1'b0, 5'b01001};
        vecs[6] = '{1'b0, 5'b00000};  // btn rises in the cycle after release_o
        vecs[7] = '{1'b1, 5'b10001};  // press two cycles after release_o
        vecs[8] = '{1'b0, 5'b01001};
        vecs[9] = '{1'b0, 5'b00000};

        rst_n = 1'b1;
        btn   = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_both("reset state", 5'b00000);
        rst_n = 1'b1;

        // Button held through reset release stays silent until released once.
        for (int i = 0; i < 100; i++) step(1'b1, 5'b00000, "held from reset");
        step(1'b0, 5'b00000, "arm release");
        step(1'b1, 5'b10001, "first press");
        step(1'b0, 5'b01001, "first release");
        step(1'b0, 5'b00000, "first idle");

        for (int i = 0; i < 10; i++) step(vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

        press_hold(20, 1'b1, "short press");
        press_hold(121, 1'b1, "long hold");
        press_hold(40, 1'b1, "release race");

        // Reset asserted mid-hold at press_o+30.
        press_hold(31, 1'b0, "pre-reset hold");
        #2 rst_n = 1'b0;
        #1 check_both("async reset", 5'b00000);
        @(negedge clk);
        check_both("in reset", 5'b00000);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b1, 5'b00000, "post-reset hold");
        step(1'b0, 5'b00000, "post-reset release");
        press_hold(45, 1'b1, "post-reset press");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
